// File: rtl/fr_eager_fork_join_pkg.sv
// +------------------------------------------------------------------+
// | fr_pkg : shared direction indices and config type for fork/join  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fr_pkg;

  localparam int DIR_N    = 0;
  localparam int DIR_E    = 1;
  localparam int DIR_S    = 2;
  localparam int DIR_W    = 3;
  localparam int DIR_FU   = 4;
  localparam int NUM_DIRS = 5;
  localparam int DIR_SEL_W = $clog2(NUM_DIRS);

  typedef struct packed {
    logic [NUM_DIRS-1:0]  join_mask;
    logic [NUM_DIRS-1:0]  fork_mask;
    logic [DIR_SEL_W-1:0] data_sel;
  } cfg_t;

endpackage

`default_nettype wire

// File: rtl/fr_eager_fork_join_tracker.sv
// +------------------------------------------------------------------+
// | eager_fork_tracker : per-output delivery state for one token     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module eager_fork_tracker #(
  parameter int NUM_OUT = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               full,
  input  logic [NUM_OUT-1:0] fork_mask,
  input  logic [NUM_OUT-1:0] out_ready,
  input  logic               clear,
  output logic [NUM_OUT-1:0] out_valid,
  output logic               complete
);

  logic [NUM_OUT-1:0] done_q;
  logic [NUM_OUT-1:0] done_d;
  logic [NUM_OUT-1:0] hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

  // An output that has already taken the token drops valid until the next one.
  always_comb begin
    out_valid = {NUM_OUT{full}} & fork_mask & ~done_q;
    hs        = out_valid & out_ready;
    complete  = full & (&(~fork_mask | done_q | hs));
  end

  always_comb begin
    done_d = done_q | hs;
    if (clear || complete) begin
      done_d = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fr_eager_fork_join.sv
// +------------------------------------------------------------------+
// | fr_eager_fork_join : masked join into a one-entry buffer,        |
// | eager fork to masked outputs. Rev 1.0                            |
// +------------------------------------------------------------------+
`default_nettype none

module fr_eager_fork_join
  import fr_pkg::*;
#(
  parameter int NUM_IN  = NUM_DIRS,
  parameter int NUM_OUT = NUM_DIRS,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  cfg_en,
  input  logic [NUM_IN-1:0]                     cfg_join_mask,
  input  logic [NUM_OUT-1:0]                    cfg_fork_mask,
  input  logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0] cfg_data_sel,
  output logic                                  cfg_ready,
  input  logic [NUM_IN-1:0]                     in_valid,
  input  logic [NUM_IN*WIDTH-1:0]               in_data,
  output logic [NUM_IN-1:0]                     in_ready,
  output logic [NUM_OUT-1:0]                    out_valid,
  output logic [WIDTH-1:0]                      out_data,
  input  logic [NUM_OUT-1:0]                    out_ready,
  output logic [CNT_W-1:0]                      tok_count
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic               full_q,      full_d;
  logic [NUM_IN-1:0]  join_mask_q, join_mask_d;
  logic [NUM_OUT-1:0] fork_mask_q, fork_mask_d;
  logic [SEL_W-1:0]   sel_q,       sel_d;
  logic [WIDTH-1:0]   data_q,      data_d;
  logic [CNT_W-1:0]   tok_count_q, tok_count_d;

  logic               fire;
  logic               complete;
  logic [WIDTH-1:0]   cap_data;

  eager_fork_tracker #(
    .NUM_OUT (NUM_OUT)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .full      (full_q),
    .fork_mask (fork_mask_q),
    .out_ready (out_ready),
    .clear     (fire),
    .out_valid (out_valid),
    .complete  (complete)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q      <= 1'b0;
      join_mask_q <= '0;
      fork_mask_q <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      tok_count_q <= '0;
    end else begin
      full_q      <= full_d;
      join_mask_q <= join_mask_d;
      fork_mask_q <= fork_mask_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      tok_count_q <= tok_count_d;
    end
  end

  // Out-of-range selects match no channel and capture zero.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_q == SEL_W'(i)) begin
        cap_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Draining and refilling in the same cycle gives the combinational out_ready -> in_ready path.
  always_comb begin
    fire = (|join_mask_q) & (&(~join_mask_q | in_valid)) & (~full_q | complete);
  end

  always_comb begin
    full_d      = full_q;
    data_d      = data_q;
    join_mask_d = join_mask_q;
    fork_mask_d = fork_mask_q;
    sel_d       = sel_q;
    tok_count_d = tok_count_q;
    if (fire) begin
      full_d = 1'b1;
      data_d = cap_data;
    end else if (complete) begin
      full_d = 1'b0;
    end
    if (complete) begin
      tok_count_d = tok_count_q + 1'b1;
    end
    if (cfg_en && !full_q) begin
      join_mask_d = cfg_join_mask;
      fork_mask_d = cfg_fork_mask;
      sel_d       = cfg_data_sel;
    end
  end

  always_comb begin
    cfg_ready = ~full_q;
    in_ready  = join_mask_q & {NUM_IN{fire}};
    out_data  = data_q;
    tok_count = tok_count_q;
  end

endmodule

`default_nettype wire
